// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential nibble multiplier: FSM encoding and nibble width.
package mult_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier.sv
// 4x4 unsigned array multiplier: AND-gate partial products summed by rows of ripple full adders.
module multiplier (
  output logic [7:0] P,
  input  logic [3:0] X,
  input  logic [3:0] Y
);

  // Full adder expressed as gates; returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    fa = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  logic [7:0] acc_s;
  logic [7:0] row_s;
  logic       c_s;

  // Add each shifted partial-product row into the running sum, one ripple row per multiplier bit.
  always_comb begin
    acc_s = {4'b0000, X & {4{Y[0]}}};
    row_s = 8'b0000_0000;
    c_s   = 1'b0;
    for (int j = 1; j < 4; j++) begin
      row_s = {4'b0000, X & {4{Y[j]}}} << j;
      c_s   = 1'b0;
      for (int k = 0; k < 8; k++) begin
        {c_s, acc_s[k]} = fa(acc_s[k], row_s[k], c_s);
      end
    end
    P = acc_s;
  end

endmodule

// File: rtl/mult_nibble_seq.sv
// Sequential W x W unsigned multiplier: walks every nibble pair through one shared 4x4 array,
// shifting each partial product into place and accumulating at full 2W precision.
module mult_nibble_seq
  import mult_seq_pkg::*;
#(
  parameter int N_DIG = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*N_DIG-1:0]     a,
  input  logic [4*N_DIG-1:0]     b,
  output logic                   busy,
  output logic                   done,
  output logic [8*N_DIG-1:0]     product
);

  localparam int W      = NIB_W * N_DIG;
  localparam int PROD_W = 2 * W;
  localparam int STEPS  = N_DIG * N_DIG;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [STEP_W-1:0] NDIG_S = STEP_W'(N_DIG);
  localparam logic [STEP_W-1:0] LAST_S = STEP_W'(STEPS - 1);

  state_t              state_r, state_s;
  logic [STEP_W-1:0]   step_r,  step_s;
  logic [W-1:0]        a_r,     a_s;
  logic [W-1:0]        b_r,     b_s;
  logic [PROD_W-1:0]   acc_r,   acc_s;
  logic [PROD_W-1:0]   product_r, product_s;
  logic                busy_r,  busy_s;
  logic                done_r,  done_s;

  logic [STEP_W-1:0]   i_s, j_s;
  logic [STEP_W+1:0]   shift_s;
  logic [3:0]          x_s, y_s;
  logic [7:0]          p_s;
  logic [PROD_W-1:0]   term_s;

  // Nibble selection for the current step and placement of the partial product.
  always_comb begin
    i_s     = step_r / NDIG_S;
    j_s     = step_r % NDIG_S;
    shift_s = {i_s + j_s, 2'b00};
    x_s     = a_r[{i_s, 2'b00} +: 4];
    y_s     = b_r[{j_s, 2'b00} +: 4];
    term_s  = PROD_W'(p_s) << shift_s;
  end

  multiplier u_array (
    .P (p_s),
    .X (x_s),
    .Y (y_s)
  );

  // Next-state and next-output logic; all outputs leave the block through registers.
  always_comb begin
    state_s   = state_r;
    step_s    = step_r;
    a_s       = a_r;
    b_s       = b_r;
    acc_s     = acc_r;
    product_s = product_r;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_s     = a;
          b_s     = b;
          acc_s   = {PROD_W{1'b0}};
          step_s  = {STEP_W{1'b0}};
          state_s = ST_MUL;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_s = acc_r + term_s;
        if (step_r == LAST_S) begin
          product_s = acc_r + term_s;
          step_s    = {STEP_W{1'b0}};
          state_s   = ST_DONE;
          done_s    = 1'b1;
        end else begin
          step_s = step_r + {{(STEP_W-1){1'b0}}, 1'b1};
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      step_r    <= {STEP_W{1'b0}};
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      acc_r     <= {PROD_W{1'b0}};
      product_r <= {PROD_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      step_r    <= step_s;
      a_r       <= a_s;
      b_r       <= b_s;
      acc_r     <= acc_s;
      product_r <= product_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_mult_nibble_seq.sv
// Self-checking bench for mult_nibble_seq at N_DIG = 1, 2 and 4 against a plain a*b reference.
module tb_mult_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start1 = 1'b0;
  logic [3:0]  a1 = 4'h0, b1 = 4'h0;
  logic        busy1, done1;
  logic [7:0]  product1;

  logic        start2 = 1'b0;
  logic [7:0]  a2 = 8'h00, b2 = 8'h00;
  logic        busy2, done2;
  logic [15:0] product2;

  logic        start4 = 1'b0;
  logic [15:0] a4 = 16'h0000, b4 = 16'h0000;
  logic        busy4, done4;
  logic [31:0] product4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_nibble_seq #(.N_DIG(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
                                     .busy(busy1), .done(done1), .product(product1));
  mult_nibble_seq #(.N_DIG(2)) dut2 (.clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
                                     .busy(busy2), .done(done2), .product(product2));
  mult_nibble_seq #(.N_DIG(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
                                     .busy(busy4), .done(done4), .product(product4));

  task automatic drive(input int sel, input logic s, input logic [31:0] av, input logic [31:0] bv);
    case (sel)
      1: begin start1 = s; a1 = av[3:0];  b1 = bv[3:0];  end
      2: begin start2 = s; a2 = av[7:0];  b2 = bv[7:0];  end
      default: begin start4 = s; a4 = av[15:0]; b4 = bv[15:0]; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      1: return done1;
      2: return done2;
      default: return done4;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1: return busy1;
      2: return busy2;
      default: return busy4;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int sel);
    case (sel)
      1: return {56'd0, product1};
      2: return {48'd0, product2};
      default: return {32'd0, product4};
    endcase
  endfunction

  // Reference: plain unsigned product of the operands truncated to the DUT width.
  function automatic logic [63:0] ref_mul(input int sel, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] mask;
    mask = (64'd1 << (4 * sel)) - 64'd1;
    return ({32'd0, av} & mask) * ({32'd0, bv} & mask);
  endfunction

  // Waits (from a negedge just after the accepting edge) for done; reports edges and busy cycles.
  task automatic wait_done(input int sel, output int lat, output int busy_cnt, output int overlap);
    lat = 0; busy_cnt = 0; overlap = 0;
    while (get_done(sel) !== 1'b1 && lat < 64) begin
      if (get_busy(sel) === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (get_busy(sel) === 1'b1 && get_done(sel) === 1'b1) overlap++;
    if (lat >= 64) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout sel=%0d: no done within %0d cycles", sel, lat);
    end
  endtask

  // One complete operation with latency, busy-width, result and hold checks.
  task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv, input string name);
    int lat, bc, ov;
    logic [63:0] exp;
    exp = ref_mul(sel, av, bv);
    @(negedge clk);
    drive(sel, 1'b1, av, bv);
    @(negedge clk);
    drive(sel, 1'b0, $urandom, $urandom);
    wait_done(sel, lat, bc, ov);
    n_cmp++;
    if (lat !== sel * sel) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, sel * sel); end
    n_cmp++;
    if (bc !== sel * sel) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, sel * sel); end
    n_cmp++;
    if (ov !== 0) begin n_bad++; $display("FAIL %s busy_with_done: got %0d want 0", name, ov); end
    n_cmp++;
    if (get_prod(sel) !== exp) begin n_bad++; $display("FAIL %s product: got %0h want %0h", name, get_prod(sel), exp); end
    @(negedge clk);
    n_cmp++;
    if (get_done(sel) !== 1'b0) begin n_bad++; $display("FAIL %s done_pulse_width: got %b want 0", name, get_done(sel)); end
    @(negedge clk);
    n_cmp++;
    if (get_prod(sel) !== exp) begin n_bad++; $display("FAIL %s product_hold: got %0h want %0h", name, get_prod(sel), exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 1; s <= 4; s = s * 2) begin
      n_cmp++;
      if (get_busy(s) !== 1'b0) begin n_bad++; $display("FAIL reset_busy sel=%0d: got %b want 0", s, get_busy(s)); end
      n_cmp++;
      if (get_done(s) !== 1'b0) begin n_bad++; $display("FAIL reset_done sel=%0d: got %b want 0", s, get_done(s)); end
      n_cmp++;
      if (get_prod(s) !== 64'd0) begin n_bad++; $display("FAIL reset_product sel=%0d: got %0h want 0", s, get_prod(s)); end
    end
  endtask

  task automatic test_fixed();
    run_op(2, 32'h00, 32'h00, "zero");
    run_op(2, 32'hFF, 32'hFF, "max8");
    run_op(2, 32'h12, 32'h34, "x12_x34");
    run_op(1, 32'hF, 32'hF, "n1_max");
    run_op(4, 32'hFFFF, 32'hFFFF, "n4_max");
  endtask

  // start held high through the DONE cycle: second op must start with no idle cycle.
  task automatic test_back_to_back();
    int lat, bc, ov;
    @(negedge clk);
    drive(2, 1'b1, 32'h12, 32'h34);
    @(negedge clk);
    drive(2, 1'b1, 32'h0F, 32'h10);
    wait_done(2, lat, bc, ov);
    n_cmp++;
    if (product2 !== 16'h03A8) begin n_bad++; $display("FAIL b2b_first: got %h want 03a8", product2); end
    @(negedge clk);
    drive(2, 1'b0, $urandom, $urandom);
    n_cmp++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_no_bubble: got busy=%b done=%b want busy=1 done=0", busy2, done2);
    end
    wait_done(2, lat, bc, ov);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    n_cmp++;
    if (product2 !== 16'h00F0) begin n_bad++; $display("FAIL b2b_second: got %h want 00f0", product2); end
    @(negedge clk);
  endtask

  // A start pulse during MUL with other operands must be ignored.
  task automatic test_ignore_start();
    int pulses;
    logic [15:0] seen;
    pulses = 0; seen = 16'h0000;
    @(negedge clk);
    drive(2, 1'b1, 32'h5A, 32'h3C);
    @(negedge clk);
    drive(2, 1'b0, 32'h00, 32'h00);
    @(negedge clk);
    drive(2, 1'b1, 32'h77, 32'h99);
    @(negedge clk);
    drive(2, 1'b0, 32'h00, 32'h00);
    for (int c = 0; c < 10; c++) begin
      if (done2 === 1'b1) begin pulses++; seen = product2; end
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", pulses); end
    n_cmp++;
    if (seen !== 16'h1518) begin n_bad++; $display("FAIL ignore_product: got %h want 1518", seen); end
  endtask

  // Reset at MUL step 2 aborts the op and clears the product; no done may follow.
  task automatic test_abort();
    int pulses;
    pulses = 0;
    @(negedge clk);
    drive(2, 1'b1, 32'hAB, 32'hCD);
    @(negedge clk);
    drive(2, 1'b0, 32'h00, 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      n_bad++; $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy2, done2);
    end
    n_cmp++;
    if (product2 !== 16'h0000) begin n_bad++; $display("FAIL abort_product: got %h want 0000", product2); end
    for (int c = 0; c < 10; c++) begin
      if (done2 === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", pulses); end
  endtask

  task automatic test_random();
    for (int s = 1; s <= 4; s = s * 2) begin
      for (int k = 0; k < 6; k++) begin
        run_op(s, $urandom, $urandom, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_ignore_start();
    run_op(2, 32'hC3, 32'h5E, "pre_abort");
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
